// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the UART boot loader: FSM states,
// default protocol bytes and the byte-enable lookup used by the word packer.
package boot_loader_pkg;

   typedef enum logic [2:0] {
      SYNC,
      DRAIN,
      ADDR,
      CNT,
      DATA,
      FLUSH,
      ON_WAIT,
      DONE
   } state_t;

   localparam logic [7:0] STP_BYTE_DEF = 8'h55;
   localparam logic [7:0] ON_BYTE_DEF  = 8'hAA;
   localparam int         SYNC_CNT_DEF = 32;
   localparam int         ON_CNT_DEF   = 32;

   // Lanes are filled from byte 0 upward, so a partial word enables the low lanes only.
   function automatic logic [3:0] be_from_lanes(input logic [2:0] lanes);
      logic [3:0] be;
      case (lanes)
         3'd1:    be = 4'b0001;
         3'd2:    be = 4'b0011;
         3'd3:    be = 4'b0111;
         3'd4:    be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/boot_word_packer.sv
// Packs payload bytes into 32-bit words and presents each finished word on a
// single-entry req/gnt staging register, flagging words dropped under backpressure.
module boot_word_packer
   import boot_loader_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_byte_vld,
   input  logic [7:0]  i_byte,
   input  logic        i_last,
   input  logic [31:0] i_word_addr,
   input  logic        i_gnt,
   output logic        o_req,
   output logic [31:0] o_addr,
   output logic [31:0] o_wdata,
   output logic [3:0]  o_be,
   output logic        o_word_done,
   output logic        o_ovf
);

   logic [1:0]  r_lane;
   logic [31:0] r_asm;
   logic        r_req;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_be;

   logic [31:0] w_word;
   logic        w_complete;
   logic        w_grant;
   logic        w_can_load;

   always_comb begin
      w_word = r_asm;
      w_word[8*r_lane +: 8] = i_byte;
   end

   assign w_complete = i_byte_vld && ((r_lane == 2'd3) || i_last);
   assign w_grant    = r_req && i_gnt;
   // A grant in the same cycle frees the slot, which is what allows back-to-back writes.
   assign w_can_load = !r_req || w_grant;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_lane <= 2'd0;
         r_asm  <= 32'd0;
      end else if (i_byte_vld) begin
         if (w_complete) begin
            r_lane <= 2'd0;
            r_asm  <= 32'd0;
         end else begin
            r_lane <= r_lane + 2'd1;
            r_asm  <= w_word;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_req   <= 1'b0;
         r_addr  <= 32'd0;
         r_wdata <= 32'd0;
         r_be    <= 4'd0;
      end else if (w_complete && w_can_load) begin
         r_req   <= 1'b1;
         r_addr  <= i_word_addr;
         r_wdata <= w_word;
         r_be    <= be_from_lanes({1'b0, r_lane} + 3'd1);
      end else if (w_grant) begin
         r_req   <= 1'b0;
      end
   end

   assign o_req       = r_req;
   assign o_addr      = r_addr;
   assign o_wdata     = r_wdata;
   assign o_be        = r_be;
   assign o_word_done = w_complete;
   assign o_ovf       = w_complete && !w_can_load;

endmodule

// File: rtl/boot_loader.sv
// UART boot-protocol receiver: decodes sync/address/count/payload/run framing,
// writes the image to memory and holds the CPU in reset until the run command.
module boot_loader
   import boot_loader_pkg::*;
#(
   parameter logic [7:0] STP_BYTE = STP_BYTE_DEF,
   parameter logic [7:0] ON_BYTE  = ON_BYTE_DEF,
   parameter int         SYNC_CNT = SYNC_CNT_DEF,
   parameter int         ON_CNT   = ON_CNT_DEF
)
(
   input  logic        Clk,
   input  logic        Rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_gnt,
   output logic        cpu_rst,
   output logic        busy,
   output logic        done,
   output logic        err_ovf,
   output logic        err_align
);

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_sync_cnt;
   logic [31:0] r_on_cnt;
   logic [31:0] r_addr_sh;
   logic [31:0] r_remaining;
   logic [31:0] r_waddr;
   logic [1:0]  r_byte_idx;
   logic        r_cpu_rst;
   logic        r_done;
   logic        r_err_ovf;
   logic        r_err_align;

   logic        w_is_stp;
   logic        w_is_on;
   logic        w_sync_hit;
   logic        w_on_hit;
   logic        w_data_byte;
   logic        w_last;
   logic [31:0] w_addr_full;
   logic [31:0] w_cnt_full;
   logic        w_req;
   logic        w_word_done;
   logic        w_ovf;

   assign w_is_stp    = rx_valid && (rx_data == STP_BYTE);
   assign w_is_on     = rx_valid && (rx_data == ON_BYTE);
   assign w_sync_hit  = ((r_state == SYNC) || (r_state == DONE)) && w_is_stp
                        && (r_sync_cnt == 32'(SYNC_CNT - 1));
   assign w_on_hit    = r_on_cnt >= 32'(ON_CNT);
   assign w_data_byte = (r_state == DATA) && rx_valid;
   assign w_last      = r_remaining == 32'd1;
   assign w_addr_full = {rx_data, r_addr_sh[31:8]};
   assign w_cnt_full  = {rx_data, r_remaining[31:8]};

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) r_state <= SYNC;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         SYNC, DONE: if (w_sync_hit) w_next = DRAIN;
         DRAIN:      if (rx_valid && !w_is_stp) w_next = ADDR;
         ADDR:       if (rx_valid && (r_byte_idx == 2'd3)) w_next = CNT;
         CNT: begin
            if (rx_valid && (r_byte_idx == 2'd3))
               w_next = (w_cnt_full == 32'd0) ? ON_WAIT : DATA;
         end
         DATA:       if (w_data_byte && w_last) w_next = FLUSH;
         FLUSH:      if (!w_req) w_next = w_on_hit ? DONE : ON_WAIT;
         ON_WAIT:    if (w_on_hit && !w_req) w_next = DONE;
         default:    w_next = SYNC;
      endcase
   end

   // Both shift registers take bytes LSB first, so the newest byte lands in [31:24].
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_sync_cnt  <= 32'd0;
         r_on_cnt    <= 32'd0;
         r_addr_sh   <= 32'd0;
         r_remaining <= 32'd0;
         r_waddr     <= 32'd0;
         r_byte_idx  <= 2'd0;
         r_cpu_rst   <= 1'b1;
         r_done      <= 1'b0;
         r_err_ovf   <= 1'b0;
         r_err_align <= 1'b0;
      end else begin
         case (r_state)
            SYNC, DONE: begin
               if (w_sync_hit) begin
                  r_sync_cnt  <= 32'd0;
                  r_on_cnt    <= 32'd0;
                  r_cpu_rst   <= 1'b1;
                  r_done      <= 1'b0;
                  r_err_ovf   <= 1'b0;
                  r_err_align <= 1'b0;
               end else if (rx_valid) begin
                  r_sync_cnt  <= w_is_stp ? r_sync_cnt + 32'd1 : 32'd0;
               end
            end
            DRAIN: begin
               if (rx_valid && !w_is_stp) begin
                  r_addr_sh  <= w_addr_full;
                  r_byte_idx <= 2'd1;
               end
            end
            ADDR: begin
               if (rx_valid) begin
                  r_addr_sh  <= w_addr_full;
                  r_byte_idx <= r_byte_idx + 2'd1;
                  if (r_byte_idx == 2'd3) begin
                     r_waddr     <= {w_addr_full[31:2], 2'b00};
                     r_err_align <= |w_addr_full[1:0];
                  end
               end
            end
            CNT: begin
               if (rx_valid) begin
                  r_remaining <= w_cnt_full;
                  r_byte_idx  <= r_byte_idx + 2'd1;
               end
            end
            DATA: begin
               if (rx_valid && (r_remaining != 32'd0))
                  r_remaining <= r_remaining - 32'd1;
               if (w_word_done)
                  r_waddr <= r_waddr + 32'd4;
            end
            FLUSH, ON_WAIT: begin
               if (rx_valid)
                  r_on_cnt <= w_is_on ? (w_on_hit ? r_on_cnt : r_on_cnt + 32'd1) : 32'd0;
               if (w_next == DONE) begin
                  r_cpu_rst <= 1'b0;
                  r_done    <= 1'b1;
               end
            end
            default: ;
         endcase
         if (w_ovf)
            r_err_ovf <= 1'b1;
      end
   end

   boot_word_packer u_packer (
      .i_clk       (Clk),
      .i_rst_n     (Rst),
      .i_byte_vld  (w_data_byte),
      .i_byte      (rx_data),
      .i_last      (w_last),
      .i_word_addr (r_waddr),
      .i_gnt       (mem_gnt),
      .o_req       (w_req),
      .o_addr      (mem_addr),
      .o_wdata     (mem_wdata),
      .o_be        (mem_be),
      .o_word_done (w_word_done),
      .o_ovf       (w_ovf)
   );

   assign mem_req   = w_req;
   assign mem_we    = w_req;
   assign cpu_rst   = r_cpu_rst;
   assign done      = r_done;
   assign busy      = (r_state != SYNC) && (r_state != DONE);
   assign err_ovf   = r_err_ovf;
   assign err_align = r_err_align;

endmodule

// File: tb/tb_boot_loader.sv
// Directed self-checking bench for boot_loader: each task drives one scenario
// and compares observed outputs and logged memory writes against hand-computed values.
module tb_boot_loader;

   logic        Clk = 1'b0;
   logic        Rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        mem_gnt;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        cpu_rst;
   logic        busy;
   logic        done;
   logic        err_ovf;
   logic        err_align;

   int checks = 0;
   int fails  = 0;

   logic [31:0] wr_addr [$];
   logic [31:0] wr_data [$];
   logic [3:0]  wr_be   [$];
   int          req_cycles = 0;

   boot_loader dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_be    (mem_be),
      .mem_gnt   (mem_gnt),
      .cpu_rst   (cpu_rst),
      .busy      (busy),
      .done      (done),
      .err_ovf   (err_ovf),
      .err_align (err_align)
   );

   always #5 Clk = ~Clk;

   // Inputs only change just after a rising edge, so the falling edge sees what the DUT will sample.
   always @(negedge Clk) begin
      if (Rst === 1'b1 && mem_req === 1'b1) begin
         req_cycles++;
         if (mem_gnt === 1'b1) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            wr_be.push_back(mem_be);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge Clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge Clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_run(input logic [7:0] b, input int n);
      repeat (n) send_byte(b);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
   endtask

   task automatic do_reset;
      Rst      = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      mem_gnt  = 1'b1;
      idle(3);
      Rst = 1'b1;
      idle(1);
   endtask

   task automatic wait_done;
      for (int i = 0; i < 8 && done !== 1'b1; i++) idle(1);
   endtask

   task automatic test_reset;
      Rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         rx_valid = 1'($urandom_range(1, 0));
         rx_data  = 8'($urandom);
         mem_gnt  = 1'($urandom_range(1, 0));
         @(posedge Clk);
         #1;
      end
      checks++;
      if ({cpu_rst, mem_req, busy, done, err_ovf, err_align} !== 6'b100000) begin
         fails++;
         $display("[TB] FAIL reset_outputs: got %b expected 100000", {cpu_rst, mem_req, busy, done, err_ovf, err_align});
      end
      checks++;
      if ({mem_addr, mem_wdata, mem_be} !== 68'd0) begin
         fails++;
         $display("[TB] FAIL reset_bus: got %h expected 0", {mem_addr, mem_wdata, mem_be});
      end
      rx_valid = 1'b0;
      Rst = 1'b1;
      idle(1);
   endtask

   task automatic test_full_boot;
      int base;
      logic [67:0] exp [2];
      do_reset();
      base = wr_addr.size();
      exp[0] = {32'h0000_0100, 32'h4433_2211, 4'hF};
      exp[1] = {32'h0000_0104, 32'h8877_6655, 4'hF};
      send_run(8'h55, 33);
      send_word(32'h0000_0100);
      send_word(32'd8);
      for (int i = 1; i <= 8; i++) send_byte(8'(i * 17));
      idle(3);
      checks++;
      if (wr_addr.size() - base !== 2) begin
         fails++;
         $display("[TB] FAIL full_wr_count: got %0d expected 2", wr_addr.size() - base);
      end
      for (int k = 0; k < 2; k++) begin
         checks++;
         if ({wr_addr[base+k], wr_data[base+k], wr_be[base+k]} !== exp[k]) begin
            fails++;
            $display("[TB] FAIL full_wr%0d: got %h expected %h", k, {wr_addr[base+k], wr_data[base+k], wr_be[base+k]}, exp[k]);
         end
      end
      send_run(8'hAA, 31);
      idle(2);
      checks++;
      if ({cpu_rst, done, busy} !== 3'b101) begin
         fails++;
         $display("[TB] FAIL full_hold_31on: got %b expected 101", {cpu_rst, done, busy});
      end
      send_byte(8'hAA);
      wait_done();
      checks++;
      if ({cpu_rst, done, busy, err_ovf, err_align} !== 5'b01000) begin
         fails++;
         $display("[TB] FAIL full_release: got %b expected 01000", {cpu_rst, done, busy, err_ovf, err_align});
      end
      send_run(8'h5A, 3);
      checks++;
      if ({cpu_rst, done} !== 2'b01) begin
         fails++;
         $display("[TB] FAIL done_ignores: got %b expected 01", {cpu_rst, done});
      end
   endtask

   task automatic test_back_to_back;
      send_run(8'h55, 32);
      checks++;
      if ({cpu_rst, done, busy} !== 3'b101) begin
         fails++;
         $display("[TB] FAIL resync_from_done: got %b expected 101", {cpu_rst, done, busy});
      end
   endtask

   task automatic test_partial_word;
      int base;
      logic [67:0] exp [2];
      do_reset();
      base = wr_addr.size();
      exp[0] = {32'h0000_0100, 32'h4433_2211, 4'hF};
      exp[1] = {32'h0000_0104, 32'h0000_6655, 4'h3};
      send_run(8'h55, 33);
      send_word(32'h0000_0100);
      send_word(32'd6);
      for (int i = 1; i <= 6; i++) send_byte(8'(i * 17));
      idle(3);
      checks++;
      if (wr_addr.size() - base !== 2) begin
         fails++;
         $display("[TB] FAIL partial_wr_count: got %0d expected 2", wr_addr.size() - base);
      end
      for (int k = 0; k < 2; k++) begin
         checks++;
         if ({wr_addr[base+k], wr_data[base+k], wr_be[base+k]} !== exp[k]) begin
            fails++;
            $display("[TB] FAIL partial_wr%0d: got %h expected %h", k, {wr_addr[base+k], wr_data[base+k], wr_be[base+k]}, exp[k]);
         end
      end
   endtask

   task automatic test_broken_sync;
      int base;
      do_reset();
      base = wr_addr.size();
      send_run(8'h55, 20);
      send_byte(8'h00);
      checks++;
      if (busy !== 1'b0) begin
         fails++;
         $display("[TB] FAIL broken_busy_a: got %b expected 0", busy);
      end
      send_run(8'h55, 31);
      checks++;
      if ({busy, cpu_rst} !== 2'b01) begin
         fails++;
         $display("[TB] FAIL broken_busy_b: got %b expected 01", {busy, cpu_rst});
      end
      send_byte(8'h55);
      checks++;
      if (busy !== 1'b1) begin
         fails++;
         $display("[TB] FAIL broken_synced: got %b expected 1", busy);
      end
      checks++;
      if (wr_addr.size() - base !== 0) begin
         fails++;
         $display("[TB] FAIL broken_no_write: got %0d expected 0", wr_addr.size() - base);
      end
      send_run(8'h55, 33);
      send_word(32'h0000_0200);
      send_word(32'd4);
      send_word(32'h0403_0201);
      idle(3);
      checks++;
      if ({wr_addr[base], wr_data[base], wr_be[base]} !== {32'h0000_0200, 32'h0403_0201, 4'hF}) begin
         fails++;
         $display("[TB] FAIL broken_frame_wr: got %h expected %h", {wr_addr[base], wr_data[base], wr_be[base]}, {32'h0000_0200, 32'h0403_0201, 4'hF});
      end
   endtask

   task automatic test_backpressure;
      int base;
      logic [67:0] exp [2];
      do_reset();
      base = wr_addr.size();
      exp[0] = {32'h0000_0100, 32'h4433_2211, 4'hF};
      exp[1] = {32'h0000_0108, 32'h9C9B_9A99, 4'hF};
      mem_gnt = 1'b0;
      send_run(8'h55, 33);
      send_word(32'h0000_0100);
      send_word(32'd12);
      for (int i = 1; i <= 8; i++) send_byte(8'(i * 17));
      checks++;
      if ({err_ovf, mem_req, mem_we, mem_addr} !== {3'b111, 32'h0000_0100}) begin
         fails++;
         $display("[TB] FAIL bp_stall: got %h expected %h", {err_ovf, mem_req, mem_we, mem_addr}, {3'b111, 32'h0000_0100});
      end
      mem_gnt = 1'b1;
      send_word(32'h9C9B_9A99);
      idle(3);
      checks++;
      if (wr_addr.size() - base !== 2) begin
         fails++;
         $display("[TB] FAIL bp_wr_count: got %0d expected 2", wr_addr.size() - base);
      end
      for (int k = 0; k < 2; k++) begin
         checks++;
         if ({wr_addr[base+k], wr_data[base+k], wr_be[base+k]} !== exp[k]) begin
            fails++;
            $display("[TB] FAIL bp_wr%0d: got %h expected %h", k, {wr_addr[base+k], wr_data[base+k], wr_be[base+k]}, exp[k]);
         end
      end
      checks++;
      if (err_ovf !== 1'b1) begin
         fails++;
         $display("[TB] FAIL bp_ovf_sticky: got %b expected 1", err_ovf);
      end
   endtask

   task automatic test_count_zero;
      int rbase;
      do_reset();
      rbase = req_cycles;
      send_run(8'h55, 33);
      send_word(32'h0000_0300);
      send_word(32'd0);
      checks++;
      if ({busy, mem_req, cpu_rst} !== 3'b101) begin
         fails++;
         $display("[TB] FAIL zero_on_wait: got %b expected 101", {busy, mem_req, cpu_rst});
      end
      send_run(8'hAA, 32);
      wait_done();
      checks++;
      if ({done, cpu_rst} !== 2'b10) begin
         fails++;
         $display("[TB] FAIL zero_done: got %b expected 10", {done, cpu_rst});
      end
      checks++;
      if (req_cycles - rbase !== 0) begin
         fails++;
         $display("[TB] FAIL zero_no_req: got %0d expected 0", req_cycles - rbase);
      end
   endtask

   task automatic test_align;
      int base;
      do_reset();
      base = wr_addr.size();
      send_run(8'h55, 33);
      send_word(32'h0000_0102);
      checks++;
      if (err_align !== 1'b1) begin
         fails++;
         $display("[TB] FAIL align_flag: got %b expected 1", err_align);
      end
      send_word(32'd4);
      send_word(32'hA4A3_A2A1);
      idle(3);
      checks++;
      if ({wr_addr[base], wr_data[base], wr_be[base]} !== {32'h0000_0100, 32'hA4A3_A2A1, 4'hF}) begin
         fails++;
         $display("[TB] FAIL align_wr: got %h expected %h", {wr_addr[base], wr_data[base], wr_be[base]}, {32'h0000_0100, 32'hA4A3_A2A1, 4'hF});
      end
   endtask

   task automatic test_reset_mid_write;
      do_reset();
      mem_gnt = 1'b0;
      send_run(8'h55, 33);
      send_word(32'h0000_0400);
      send_word(32'd4);
      send_word(32'h1234_5678);
      checks++;
      if ({mem_req, mem_addr} !== {1'b1, 32'h0000_0400}) begin
         fails++;
         $display("[TB] FAIL midrst_pending: got %h expected %h", {mem_req, mem_addr}, {1'b1, 32'h0000_0400});
      end
      Rst = 1'b0;
      #1;
      checks++;
      if ({mem_req, mem_we, cpu_rst, busy, mem_addr, mem_wdata, mem_be} !== {4'b0010, 68'd0}) begin
         fails++;
         $display("[TB] FAIL midrst_clear: got %h expected %h", {mem_req, mem_we, cpu_rst, busy, mem_addr, mem_wdata, mem_be}, {4'b0010, 68'd0});
      end
      idle(2);
      Rst = 1'b1;
      mem_gnt = 1'b1;
      idle(1);
   endtask

   initial begin
      Rst      = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      mem_gnt  = 1'b1;
      test_reset();
      test_full_boot();
      test_back_to_back();
      test_partial_word();
      test_broken_sync();
      test_backpressure();
      test_count_zero();
      test_align();
      test_reset_mid_write();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Target-side receiver of the UART boot protocol; the host-side sender is the UART boot-image tester.
- Consumes the received byte stream from the UART RX byte interface and decodes the frame: sync run, start address, byte count, image payload, then run-command run.
- Packs payload bytes into 32-bit words and writes them to instruction/data memory over a req/gnt write port.
- Holds the CPU in reset until the image is loaded and the run command is received.

Parameters:
- STP_BYTE, 8'h55, sync ("stop CPU, start load") byte value.
- ON_BYTE, 8'hAA, run-command byte value.
- SYNC_CNT, 32, consecutive STP_BYTE count required to sync; the sender transmits 33.
- ON_CNT, 32, consecutive ON_BYTE count required to release the CPU.

Ports:
- Clk  in  1  system clock.
- Rst  in  1  asynchronous reset, active-low.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe, rx_data valid.
- mem_req  out  1  write request.
- mem_we  out  1  write enable; equals mem_req.
- mem_addr  out  32  word-aligned byte address, bits [1:0]=0.
- mem_wdata  out  32  write data, byte 0 in [7:0].
- mem_be  out  4  byte enables.
- mem_gnt  in  1  request accepted this cycle.
- cpu_rst  out  1  CPU reset hold, active-high.
- busy  out  1  frame in progress (any state other than SYNC/DONE).
- done  out  1  boot complete.
- err_ovf  out  1  sticky: payload word dropped.
- err_align  out  1  sticky: start address low bits non-zero.

Behaviour:
- Reset (Rst=0, async): state SYNC, all counters 0.
  - Outputs: mem_req/mem_we=0, mem_addr/mem_wdata=0, mem_be=0, cpu_rst=1, busy=0, done=0, err_ovf=0, err_align=0.
- Only bytes with rx_valid=1 are processed; at most one per cycle.
- SYNC:
  - STP_BYTE increments sync_cnt; any other byte clears it.
  - When sync_cnt reaches SYNC_CNT: go to DRAIN, set cpu_rst=1, done=0, clear both error flags.
- DRAIN: further STP_BYTE bytes are discarded. The first non-STP byte is address byte 0 and moves the FSM to ADDR. An address LSB equal to STP_BYTE is therefore unsupported.
- ADDR: 4 bytes, LSB first, into addr register.
  - On the 4th byte: set err_align if addr[1:0]!=0; use addr with bits [1:0] forced to 0; go to CNT.
- CNT: 4 bytes, LSB first, into remaining[31:0].
  - On the 4th byte: remaining==0 → ON_WAIT; otherwise → DATA.
- DATA:
  - Each byte goes to assembly lane lane_idx, then lane_idx++ and remaining--.
  - The word is complete when lane_idx wraps 3→0 or remaining reaches 0.
  - A completed word moves to the staging register with be = lanes filled (partial final word: e.g. 2 bytes → 4'b0011, unfilled lanes 0). The word address then advances by 4.
  - After the last byte go to FLUSH.
- Staging / bus:
  - mem_req rises the cycle after the completing byte's rx_valid.
  - mem_addr, mem_wdata and mem_be stay stable while mem_req=1, until mem_gnt=1 is sampled.
  - mem_req drops the next cycle, unless the staging register was refilled in the same cycle as gnt; back-to-back requests are allowed.
  - Overflow: a word completes while staging is full and not granted that cycle → the new word is dropped, err_ovf=1, decoding continues, and its address still advances.
- FLUSH: wait until staging is empty, then go to ON_WAIT.
- ON detection runs in FLUSH and ON_WAIT:
  - ON_BYTE increments on_cnt; any other byte clears it.
  - When on_cnt>=ON_CNT and staging is empty: go to DONE; cpu_rst=0 and done=1, registered, on the next cycle.
- DONE: a fresh SYNC_CNT STP run re-enters DRAIN and reasserts cpu_rst; all other bytes are ignored.
- Reset mid-frame: all outputs return to reset values immediately and any pending write is abandoned.
- Width rules: remaining is 32-bit with no wrap below 0. The address increment wraps modulo 2^32.

Decomposition:
- boot_loader_pkg:
  - state enum: SYNC, DRAIN, ADDR, CNT, DATA, FLUSH, ON_WAIT, DONE.
  - default STP/ON byte constants.
  - BE lookup from lane count.
- Sub-module boot_word_packer: lane assembly, staging register, req/gnt handshake and overflow detection. The FSM and counters stay in boot_loader.

Test Plan:
- Reset: hold Rst=0 for 5 cycles with random rx traffic → cpu_rst=1, mem_req=0, busy=0, done=0.
- Full boot, mem_gnt tied 1:
  - Stimulus: 33×55, address bytes 00 01 00 00, count bytes 08 00 00 00, payload 11..88, then 33×AA.
  - Required: write 0x100/0x44332211/F, then write 0x104/0x88776655/F; cpu_rst falls after the 32nd AA; done=1.
- Partial word: count 06, payload 11..66 → second write 0x104/0x00006655/be 0011.
- Broken sync: 20×55, 00, 32×55, then frame → no write and busy=0 until the second run completes.
- Backpressure:
  - Stimulus: mem_gnt=0 while 8 payload bytes arrive, then gnt=1.
  - Required: err_ovf=1; only 0x100/0x44332211 is written; the next word goes to 0x108.
- Edge cases:
  - count 0 → no mem_req; done=1 after the ON run.
  - Start address 0x102 → err_align=1; writes begin at 0x100.
  - Rst=0 asserted while mem_req=1 → mem_req=0 at once.
